// File: rtl/box_area_accumulator_pkg.sv
// box_area_accumulator_pkg: shared SPU constants, readout state type and default widths.
// Contents:
//   FRAME_NIBBLES   number of nibbles in one readout frame
//   FRAME_W         bit width of one packed frame
//   SUM_W_DEF       default width of the saturating sum
//   CNT_W_DEF       default width of the saturating sample count
//   state_t         readout FSM states (ACC: accumulating, DUMP: streaming a frame)
package box_area_accumulator_pkg;
    localparam int FRAME_NIBBLES = 6;
    localparam int FRAME_W       = 4 * FRAME_NIBBLES;
    localparam int SUM_W_DEF     = 12;
    localparam int CNT_W_DEF     = 4;
    typedef enum logic {ACC, DUMP} state_t;
endpackage

// File: rtl/box_area_accumulator_if.sv
// box_area_accumulator_if: sample input, control and nibble-stream signals of the accumulator.
// Signals:
//   in_valid, area_high, area_low   area sample strobe and its nibbles
//   clear, rd_start                 zero live statistics / request snapshot and readout
//   out_ready                       consumer accepts the current nibble
//   out_valid, out_nibble, out_last readout stream
//   busy, sat                       readout in progress / live sum has saturated
// Modports: master drives samples and control, slave is the accumulator.
interface box_area_accumulator_if;
    logic       in_valid;
    logic [3:0] area_high;
    logic [3:0] area_low;
    logic       clear;
    logic       rd_start;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_nibble;
    logic       out_last;
    logic       busy;
    logic       sat;
    modport master (
        output in_valid, area_high, area_low, clear, rd_start, out_ready,
        input  out_valid, out_nibble, out_last, busy, sat
    );
    modport slave (
        input  in_valid, area_high, area_low, clear, rd_start, out_ready,
        output out_valid, out_nibble, out_last, busy, sat
    );
endinterface

// File: rtl/box_area_accumulator_stat_update.sv
// box_area_accumulator_stat_update: combinational next-value of the live statistics.
// Ports:
//   i_valid, i_clear, i_area      sample strobe, clear request, 8-bit area
//   i_sum, i_max, i_cnt, i_sat    current live statistics
//   o_sum, o_max, o_cnt, o_sat    statistics after this cycle's clear and sample
module box_area_accumulator_stat_update
    import box_area_accumulator_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_valid,
    input  logic             i_clear,
    input  logic [7:0]       i_area,
    input  logic [SUM_W-1:0] i_sum,
    input  logic [7:0]       i_max,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_sat,
    output logic [SUM_W-1:0] o_sum,
    output logic [7:0]       o_max,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);
    logic [SUM_W-1:0] w_sum;
    logic [7:0]       w_max;
    logic [CNT_W-1:0] w_cnt;
    logic             w_sat;
    logic [SUM_W:0]   w_add;
    logic             w_ovf;
    // Clear is applied first so a sample in the same cycle restarts the statistics.
    always_comb begin
        w_sum = i_clear ? '0 : i_sum;
        w_max = i_clear ? '0 : i_max;
        w_cnt = i_clear ? '0 : i_cnt;
        w_sat = i_clear ? 1'b0 : i_sat;
        w_add = {1'b0, w_sum} + (SUM_W+1)'(i_area);
        w_ovf = w_add[SUM_W];
        o_sum = !i_valid ? w_sum : (w_ovf ? '1 : w_add[SUM_W-1:0]);
        o_max = (i_valid && i_area > w_max) ? i_area : w_max;
        o_cnt = (i_valid && w_cnt != '1) ? w_cnt + CNT_W'(1) : w_cnt;
        o_sat = w_sat | (i_valid & w_ovf);
    end
endmodule

// File: rtl/box_area_accumulator.sv
// box_area_accumulator: running area statistics with a snapshot streamed out as nibbles.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    slave side of box_area_accumulator_if (samples, control, nibble stream, status)
module box_area_accumulator
    import box_area_accumulator_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    box_area_accumulator_if.slave bus
);
    state_t           r_state, w_state_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [SUM_W-1:0] r_sum, w_sum_nxt;
    logic [7:0]       r_max, w_max_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_sat, w_sat_nxt;
    logic [FRAME_W-1:0] r_snap, w_frame, w_frame_sh;
    logic             w_load;

    box_area_accumulator_stat_update #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_stat (
        .i_valid (bus.in_valid),
        .i_clear (bus.clear),
        .i_area  ({bus.area_high, bus.area_low}),
        .i_sum   (r_sum),
        .i_max   (r_max),
        .i_cnt   (r_cnt),
        .i_sat   (r_sat),
        .o_sum   (w_sum_nxt),
        .o_max   (w_max_nxt),
        .o_cnt   (w_cnt_nxt),
        .o_sat   (w_sat_nxt)
    );

    // The snapshot takes the post-update values so a sample in the rd_start cycle is included.
    assign w_frame = {12'(w_sum_nxt), w_max_nxt, 4'(w_cnt_nxt)};
    assign w_load  = (r_state == ACC) && bus.rd_start;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_load) begin
            w_state_nxt = DUMP;
            w_idx_nxt   = '0;
        end else if (r_state == DUMP && bus.out_ready) begin
            w_state_nxt = (r_idx == 3'(FRAME_NIBBLES-1)) ? ACC : DUMP;
            w_idx_nxt   = r_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACC;
            r_idx   <= '0;
            r_sum   <= '0;
            r_max   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            r_snap  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_sum   <= w_sum_nxt;
            r_max   <= w_max_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sat   <= w_sat_nxt;
            if (w_load) r_snap <= w_frame;
        end
    end

    // Most significant nibble goes first; outputs decode registered state only.
    assign w_frame_sh     = r_snap << {r_idx, 2'b00};
    assign bus.busy       = (r_state == DUMP);
    assign bus.out_valid  = (r_state == DUMP);
    assign bus.out_nibble = bus.busy ? w_frame_sh[FRAME_W-1 -: 4] : 4'h0;
    assign bus.out_last   = bus.busy && (r_idx == 3'(FRAME_NIBBLES-1));
    assign bus.sat        = r_sat;
endmodule
